// File: rtl/loader_pkg.sv
// Shared types and frame constants for the UART instruction-memory boot loader.
// The CHECK state is only entered when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        WAIT_LEN0,
        WAIT_LEN1,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser and centre-of-bit sampling.
// Emits one-cycle rx_valid (good stop bit) or rx_ferr (stop bit low) pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    output logic                      rx_ferr
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    rx_state_e                 state_q, state_d;
    logic                      sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      fall_edge;

    // Edge (not level) start detection so a line stuck low after a framing error cannot retrigger.
    assign fall_edge = prev_q && !sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall_edge) state_d = RX_START;
            RX_START: if (cnt_q == HALF_CNT) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_q == FULL_CNT && bit_q == LAST_BIT) state_d = RX_STOP;
            RX_STOP:  if (cnt_q == FULL_CNT) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: begin
                if (cnt_q == HALF_CNT) cnt_d = '0;
            end
            RX_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a length-prefixed image and writes it into instruction memory,
// holding the core in reset until done. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 64,
    parameter int CLKS_PER_BIT = 868,
    localparam int WORD_BYTES  = DATA_W / 8,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int BC_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(WORD_BYTES - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_LOAD = CHECK;
`else
    localparam loader_state_e AFTER_LOAD = DONE;
`endif

    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      rx_valid, rx_ferr;

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  len_full;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign len_full  = {rx_byte, len_q[7:0]};
    assign last_word = (LEN_W'(addr_q) == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LEN0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LEN0: begin
                if (rx_ferr) state_d = ERROR;
                else if (rx_valid) state_d = WAIT_LEN1;
            end
            WAIT_LEN1: begin
                if (rx_ferr) state_d = ERROR;
                else if (rx_valid) begin
                    if (len_full == '0) state_d = AFTER_LOAD;
                    else if (len_full > DEPTH_L) state_d = ERROR;
                    else state_d = LOAD;
                end
            end
            LOAD: begin
                if (rx_ferr) state_d = ERROR;
                else if (rx_valid && byte_cnt_q == LAST_BYTE && last_word) state_d = AFTER_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_ferr) state_d = ERROR;
                else if (rx_valid) state_d = (8'(rx_byte + sum_q) == 8'h00) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (reload) state_d = WAIT_LEN0;
            end
            default: state_d = ERROR;
        endcase
    end

    // Word assembly, write strobe and address stepping; the address advances in the write cycle.
    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        if (rx_valid && (state_q == WAIT_LEN0 || state_q == WAIT_LEN1 || state_q == LOAD)) begin
            sum_d = sum_q + rx_byte;
        end
`endif
        if (state_q == LOAD && we_q) addr_d = addr_q + 1'b1;
        case (state_q)
            WAIT_LEN0: begin
                if (rx_valid) len_d = {len_q[LEN_W-1:8], rx_byte};
            end
            WAIT_LEN1: begin
                if (rx_valid) begin
                    len_d      = len_full;
                    byte_cnt_d = '0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    wdata_d[8*byte_cnt_q +: 8] = rx_byte;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        we_d       = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (reload) begin
                    addr_d     = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_rst_n_d = (state_q == DONE);
        done_d      = (state_q == DONE);
        err_d       = (state_q == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: table of images plus hand-written error/reload/reset sequences.
// Works with or without LOADER_CHECKSUM_EN; the checksum byte is computed here when enabled.
module tb_uart_imem_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CPB    = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]      len;
        logic [1:0]       nSend;
        logic [2:0][31:0] words;
        logic [1:0]       nWr;
        logic             expDone;
        logic             expErr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rxd = 1'b1;
    logic              reload = 1'b0;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              cpuRstN;
    logic              loadDone;
    logic              loadErr;

    int                checks = 0;
    int                errors = 0;
    logic [7:0]        ckSum;
    logic [ADDR_W-1:0] wrAddr[$];
    logic [DATA_W-1:0] wrData[$];
    vec_t              vecs[5];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .reload   (reload),
        .mem_we   (memWe),
        .mem_addr (memAddr),
        .mem_wdata(memWdata),
        .cpu_rst_n(cpuRstN),
        .load_done(loadDone),
        .load_err (loadErr)
    );

    always @(negedge clk) begin
        if (memWe) begin
            wrAddr.push_back(memAddr);
            wrData.push_back(memWdata);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic expDone, input logic expErr);
        checkOutput({tag, " load_done"}, 32'(loadDone), 32'(expDone));
        checkOutput({tag, " load_err"}, 32'(loadErr), 32'(expErr));
        checkOutput({tag, " cpu_rst_n"}, 32'(cpuRstN), 32'(expDone));
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [31:0] expData);
        if (idx >= wrData.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s write %0d: got no write, expected data 0x%0h", tag, idx, expData);
        end else begin
            checkOutput($sformatf("%s wr%0d addr", tag, idx), 32'(wrAddr[idx]), 32'(idx));
            checkOutput($sformatf("%s wr%0d data", tag, idx), wrData[idx], expData);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stopBit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic sendData(input logic [7:0] b);
        ckSum = ckSum + b;
        sendByte(b, 1'b1);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sendData(w[8*k +: 8]);
    endtask

    task automatic startImage(input logic [15:0] len);
        ckSum = 8'h00;
        wrAddr.delete();
        wrData.delete();
        sendData(len[7:0]);
        sendData(len[15:8]);
    endtask

    task automatic endImage();
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'h00 - ckSum, 1'b1);
`endif
        repeat (8) @(negedge clk);
    endtask

    task automatic pulseReload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput({tag, " reload mem_addr"}, 32'(memAddr), 32'd0);
        checkState({tag, " reload"}, 1'b0, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        startImage(v.len);
        for (int i = 0; i < int'(v.nSend); i++) sendWord(v.words[i]);
        endImage();
    endtask

    initial begin
        vecs[0] = '{16'd2, 2'd2, {32'h0, 32'h00200093, 32'h003100B3}, 2'd2, 1'b1, 1'b0};
        vecs[1] = '{16'd0, 2'd0, {32'h0, 32'h0, 32'h0}, 2'd0, 1'b1, 1'b0};
        vecs[2] = '{16'd9, 2'd0, {32'h0, 32'h0, 32'h0}, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{16'd1, 2'd1, {32'h0, 32'h0, 32'hDEADBEEF}, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{16'd3, 2'd3, {32'h04030201, 32'h88776655, 32'h44332211}, 2'd3, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        checkOutput("reset mem_we", 32'(memWe), 32'd0);
        checkOutput("reset mem_addr", 32'(memAddr), 32'd0);
        checkOutput("reset mem_wdata", memWdata, 32'd0);
        checkState("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post-reset cpu_rst_n", 32'(cpuRstN), 32'd0);

        for (int n = 0; n < 5; n++) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            if (n > 0) pulseReload(tag);
            applyStimulus(vecs[n]);
            checkOutput({tag, " write count"}, 32'(wrData.size()), 32'(vecs[n].nWr));
            for (int i = 0; i < int'(vecs[n].nWr); i++) checkWrite(tag, i, vecs[n].words[i]);
            checkState(tag, vecs[n].expDone, vecs[n].expErr);
        end

        // Framing error on the third data byte, then recovery with a one-word image.
        pulseReload("ferr");
        startImage(16'd2);
        sendData(8'hB3);
        sendData(8'h00);
        sendByte(8'h31, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("ferr write count", 32'(wrData.size()), 32'd0);
        checkState("ferr", 1'b0, 1'b1);
        pulseReload("ferr recover");
        startImage(16'd1);
        sendWord(32'h12345678);
        endImage();
        checkOutput("recover write count", 32'(wrData.size()), 32'd1);
        checkWrite("recover", 0, 32'h12345678);
        checkState("recover", 1'b1, 1'b0);

        // 100 ns glitch in idle must not be taken as a start bit.
        pulseReload("glitch");
        @(negedge clk);
        rxd = 1'b0;
        #100;
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkState("glitch idle", 1'b0, 1'b0);
        startImage(16'd1);
        sendWord(32'h0BADC0DE);
        endImage();
        checkOutput("glitch write count", 32'(wrData.size()), 32'd1);
        checkWrite("glitch", 0, 32'h0BADC0DE);
        checkState("glitch", 1'b1, 1'b0);

        // Full-depth image: last word lands at DEPTH-1.
        pulseReload("full");
        startImage(16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) sendWord({8'(i + 48), 8'(i + 32), 8'(i + 16), 8'(i)});
        endImage();
        checkOutput("full write count", 32'(wrData.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) checkWrite("full", i, {8'(i + 48), 8'(i + 32), 8'(i + 16), 8'(i)});
        checkState("full", 1'b1, 1'b0);

        // reload between the two length bytes is ignored.
        pulseReload("midreload");
        ckSum = 8'h00;
        wrAddr.delete();
        wrData.delete();
        sendData(8'h01);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        sendData(8'h00);
        sendWord(32'hCAFEF00D);
        endImage();
        checkOutput("midreload write count", 32'(wrData.size()), 32'd1);
        checkWrite("midreload", 0, 32'hCAFEF00D);
        checkState("midreload", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        pulseReload("badck");
        startImage(16'd2);
        sendWord(32'h003100B3);
        sendWord(32'h00200093);
        sendByte((8'h00 - ckSum) ^ 8'h5A, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("badck write count", 32'(wrData.size()), 32'd2);
        checkWrite("badck", 1, 32'h00200093);
        checkState("badck", 1'b0, 1'b1);
`endif

        // Asynchronous reset in the middle of a byte.
        wrAddr.delete();
        wrData.delete();
        @(negedge clk);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset mem_we", 32'(memWe), 32'd0);
        checkOutput("midreset mem_addr", 32'(memAddr), 32'd0);
        checkOutput("midreset mem_wdata", memWdata, 32'd0);
        checkState("midreset", 1'b0, 1'b0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        checkOutput("midreset write count", 32'(wrData.size()), 32'd0);
        checkState("after midreset", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
